// File: rtl/datapath_pkg.sv
// Shared constants for the single-cycle execution datapath.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package datapath_pkg;

  // ALU operation select codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  // Instruction field positions within the 26-bit INST bus
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Replicate imm[15] into the upper half word
  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Instruction and control bundle between the control unit and the datapath.
// Latency: none (wires only).
// Backpressure: none; the datapath consumes a new instruction every cycle.
interface datapath_if;
  logic [25:0] INST;
  logic        REGDST;
  logic        ALUSRC;
  logic        MEMWRITE;
  logic        MEMREAD;
  logic [3:0]  ALUCONTROL;
  logic        MEMTOREG;
  logic        REGWRITE;
  logic [31:0] OUT;

  modport master (
    output INST, REGDST, ALUSRC, MEMWRITE, MEMREAD, ALUCONTROL, MEMTOREG, REGWRITE,
    input  OUT
  );

  modport slave (
    input  INST, REGDST, ALUSRC, MEMWRITE, MEMREAD, ALUCONTROL, MEMTOREG, REGWRITE,
    output OUT
  );
endinterface

// File: rtl/datapath_regfile.sv
// 32x32 register file, two asynchronous read ports and one write port; R0 reads zero.
// Latency: reads combinational, write visible after the next rising edge (no bypass).
// Backpressure: none; a write is accepted every cycle.
module datapath_regfile (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rda_o,
  output logic [31:0] rdb_o
);

  logic [31:0] regs_q [32];

  // Reset loads R[i]=i; writes to R0 are dropped so entry 0 stays zero
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'(i);
      end
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read ports see only committed state, so same-cycle writes return old data
  always_comb begin
    rda_o = (ra_i == 5'd0) ? 32'd0 : regs_q[ra_i];
    rdb_o = (rb_i == 5'd0) ? 32'd0 : regs_q[rb_i];
  end

endmodule

// File: rtl/datapath.sv
// Single-cycle execution datapath: register file, ALU, data memory and write-back muxes.
// Latency: OUT combinational from INST/controls; register/memory updates at the next rising edge.
// Backpressure: none; one instruction is executed every cycle.
module datapath
  import datapath_pkg::*;
#(
  parameter int DMEM_DEPTH = 64
) (
  input  logic     CLK,
  input  logic     RST_N,
  datapath_if.slave bus
);

  localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [4:0]    rs, rt, rd, dest;
  logic [15:0]   imm;
  logic [31:0]   rf_a, rf_b, alu_b, alu_res, rd_dat, wb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_q [DMEM_DEPTH];

  assign rs  = bus.INST[RS_MSB:RS_LSB];
  assign rt  = bus.INST[RT_MSB:RT_LSB];
  assign rd  = bus.INST[RD_MSB:RD_LSB];
  assign imm = bus.INST[IMM_MSB:IMM_LSB];

  datapath_regfile u_regfile (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .ra_i    (rs),
    .rb_i    (rt),
    .wa_i    (dest),
    .we_i    (bus.REGWRITE),
    .wd_i    (wb),
    .rda_o   (rf_a),
    .rdb_o   (rf_b)
  );

  // Operand B select and destination select
  always_comb begin
    alu_b = bus.ALUSRC ? sign_ext(imm) : rf_b;
    dest  = bus.REGDST ? rd : rt;
  end

  // ALU: wraps modulo 2^32, unknown codes yield zero
  always_comb begin
    alu_res = 32'd0;
    case (bus.ALUCONTROL)
      ALU_AND: alu_res = rf_a & alu_b;
      ALU_OR:  alu_res = rf_a | alu_b;
      ALU_XOR: alu_res = rf_a ^ alu_b;
      ALU_NOR: alu_res = ~(rf_a | alu_b);
      ALU_ADD: alu_res = rf_a + alu_b;
      ALU_SUB: alu_res = rf_a - alu_b;
      ALU_SLT: alu_res = ($signed(rf_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALU_SLL: alu_res = alu_b << rf_a[4:0];
      ALU_SRL: alu_res = alu_b >> rf_a[4:0];
      default: alu_res = 32'd0;
    endcase
  end

  // Memory read and write-back select; upper address bits are dropped so accesses wrap
  always_comb begin
    mem_addr = alu_res[AW-1:0];
    rd_dat   = bus.MEMREAD ? mem_q[mem_addr] : 32'd0;
    wb       = bus.MEMTOREG ? rd_dat : alu_res;
    bus.OUT  = wb;
  end

  // Data memory write of R[rt]; reset clears every word
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (bus.MEMWRITE) begin
      mem_q[mem_addr] <= rf_b;
    end
  end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  localparam int DEPTH = 64;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic CLK;
  logic RST_N;
  datapath_if bus();

  datapath #(.DMEM_DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model state
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [DEPTH];

  exp_t exp_q[$];
  logic chk_vld;
  logic done;
  int   n_checks;
  int   n_fail;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd3: return ~(a | b);
      4'd5: return a + b;
      4'd6: return a - b;
      4'd7: return (sa < sb) ? 32'd1 : 32'd0;
      4'd8: return b << (a % 32);
      4'd9: return b >> (a % 32);
      default: return 32'd0;
    endcase
  endfunction

  // Apply one instruction for one cycle: predict OUT, then commit the model at the edge
  task automatic do_op(input string name, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic regdst,
                       input logic alusrc, input logic memwrite, input logic memread,
                       input logic [3:0] aluc, input logic memtoreg, input logic regwrite);
    logic [31:0] a, b, bsel, alu, rdat, wb;
    int addr;
    exp_t e;
    bus.INST       = {rs, rt, imm};
    if (rd != imm[15:11]) bus.INST[15:11] = rd;
    bus.REGDST     = regdst;
    bus.ALUSRC     = alusrc;
    bus.MEMWRITE   = memwrite;
    bus.MEMREAD    = memread;
    bus.ALUCONTROL = aluc;
    bus.MEMTOREG   = memtoreg;
    bus.REGWRITE   = regwrite;
    // rd overlays imm[15:11]; the model uses what is actually on the bus
    rd   = bus.INST[15:11];
    imm  = bus.INST[15:0];
    a    = m_reg[rs];
    b    = m_reg[rt];
    bsel = alusrc ? 32'($signed(imm)) : b;
    alu  = model_alu(aluc, a, bsel);
    addr = int'(alu % 32'(DEPTH));
    rdat = memread ? m_mem[addr] : 32'd0;
    wb   = memtoreg ? rdat : alu;
    e.name = name;
    e.exp  = wb;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(posedge CLK);
    if (RST_N) begin
      if (memwrite) m_mem[addr] = b;
      if (regwrite && ((regdst ? rd : rt) != 5'd0)) m_reg[regdst ? rd : rt] = wb;
    end
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic read_reg(input int k);
    do_op("read_reg", 5'(k), 5'd0, 5'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);
  endtask

  task automatic read_mem(input int k);
    do_op("read_mem", 5'd0, 5'd0, 5'd0, 16'(k), 1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, 1'b1, 1'b0);
  endtask

  // Monitor: compares OUT mid-cycle whenever the driver has an instruction on the bus
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (done) begin
        n_checks++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
      if (chk_vld) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: OUT=%h presented with no expectation", bus.OUT);
        end else begin
          e = exp_q.pop_front();
          if (bus.OUT !== e.exp) begin
            n_fail++;
            $display("FAIL %s at %0t: OUT=%h required %h", e.name, $time, bus.OUT, e.exp);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_vld  = 1'b0;
    done     = 1'b0;
    bus.INST = '0; bus.REGDST = 0; bus.ALUSRC = 0; bus.MEMWRITE = 0; bus.MEMREAD = 0;
    bus.ALUCONTROL = '0; bus.MEMTOREG = 0; bus.REGWRITE = 0;
    RST_N = 1'b0;
    model_reset();
    #12 RST_N = 1'b1;
    @(posedge CLK); #1;

    // Reset contents
    for (int k = 0; k < 4; k++) read_reg(k);
    read_mem(2);
    // 1. ADD $1,$2,$3
    do_op("add", 5'd2, 5'd3, 5'd1, 16'd0, 1, 0, 0, 0, 4'b0101, 0, 1);
    read_reg(1);
    // 2. SW $1,0($2)
    do_op("sw", 5'd2, 5'd1, 5'd0, 16'd0, 0, 1, 1, 0, 4'b0101, 0, 0);
    read_mem(2);
    // 3. LW $4,0($2), then with MEMREAD low
    do_op("lw", 5'd2, 5'd4, 5'd0, 16'd0, 0, 1, 0, 1, 4'b0101, 1, 1);
    read_reg(4);
    do_op("lw_noread", 5'd2, 5'd4, 5'd0, 16'd0, 0, 1, 0, 0, 4'b0101, 1, 0);
    // 4. Write to R0 is discarded
    do_op("add_r0", 5'd2, 5'd3, 5'd0, 16'd0, 1, 0, 0, 0, 4'b0101, 0, 1);
    read_reg(0);
    // 5. Sign extension, wrap, signed compare
    do_op("addi_neg", 5'd1, 5'd0, 5'd0, 16'hFFFF, 0, 1, 0, 0, 4'b0101, 0, 0);
    do_op("sub_wrap", 5'd0, 5'd1, 5'd6, 16'd0, 1, 0, 0, 0, 4'b0110, 0, 1);
    do_op("slt_neg", 5'd6, 5'd3, 5'd0, 16'd0, 1, 0, 0, 0, 4'b0111, 0, 0);
    // Memory address wrap: R2 + 64 hits word 2
    do_op("mem_wrap", 5'd2, 5'd0, 5'd0, 16'(DEPTH), 0, 1, 0, 1, 4'b0101, 1, 0);

    // Randomised instructions
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      r = $urandom;
      do_op("random", 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
            r[0], r[1], r[2], r[3], (r[8]) ? 4'($urandom_range(0, 9)) : 4'($urandom),
            r[4], r[5] | r[6]);
    end
    for (int k = 0; k < 32; k++) read_reg(k);
    for (int k = 0; k < DEPTH; k++) read_mem(k);

    // 6. Reset asserted between edges with REGWRITE held high
    do_op("pre_rst", 5'd2, 5'd3, 5'd7, 16'd0, 1, 0, 1, 0, 4'b0101, 0, 1);
    #2;
    RST_N = 1'b0;
    model_reset();
    do_op("in_rst", 5'd2, 5'd3, 5'd7, 16'd0, 1, 0, 1, 0, 4'b0101, 0, 1);
    do_op("in_rst", 5'd1, 5'd1, 5'd9, 16'd0, 1, 0, 1, 0, 4'b0101, 0, 1);
    RST_N = 1'b1;
    for (int k = 0; k < 32; k++) read_reg(k);
    for (int k = 0; k < 8; k++) read_mem(k);

    done = 1'b1;
  end

endmodule
